// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler sharing one serial DAC between NREQ sample requesters.
// Define DAC_AUTOPD_EN to send a single power-down frame after PD_TIMEOUT idle clocks.
module dac_frame_scheduler #(
    parameter int          NREQ       = 4,
    parameter int          CLKDIV     = 1,
    parameter logic [7:0]  CMD_BASE   = 8'h53,
    parameter int          GAP_CYC    = 2,
    parameter int          PD_TIMEOUT = 4096,
    parameter logic [15:0] PD_FRAME   = 16'h3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] sample,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [1:0]        gnt_id,
    output logic              sclk,
    output logic              sync,
    output logic              din
);

    localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [15:0]     shift_reg, shift_n;
    logic [3:0]      bit_cnt, bit_n;
    logic [7:0]      hc, hc_n;
    logic [GCW-1:0]  gap_cnt, gap_n;
    logic            sclk_n, sync_n, din_n, busy_n;
    logic [NREQ-1:0] ack_n;
    logic [1:0]      gnt_n;

`ifdef DAC_AUTOPD_EN
    localparam int PDW = $clog2(PD_TIMEOUT + 1);
    logic [PDW-1:0]  idle_cnt, idle_n;
    logic            last_pd, last_pd_n;
`endif

    logic [3:0]  req_ext;
    logic [31:0] sample_ext;
    logic        found;
    logic [1:0]  win, idx;
    logic [7:0]  win_sample;
    logic [3:0]  ack_onehot;
    logic [15:0] frame_real, load_frame;
    logic        load, load_real;

    // Narrow configurations are zero-extended so the arbiter always works on four slots.
    always_comb begin
        req_ext                 = '0;
        req_ext[NREQ-1:0]       = req;
        sample_ext              = '0;
        sample_ext[8*NREQ-1:0]  = sample;
    end

    // First pending requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        win_sample = '0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = 2'((int'(ptr) + k) % NREQ);
            if (!found && req_ext[idx]) begin
                found      = 1'b1;
                win        = idx;
                win_sample = sample_ext[{idx, 3'b000} +: 8];
            end
        end
    end

    assign frame_real = {CMD_BASE[7:2], win, win_sample};
    assign ack_onehot = 4'b0001 << win;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        shift_n    = shift_reg;
        bit_n      = bit_cnt;
        hc_n       = hc;
        gap_n      = gap_cnt;
        sclk_n     = sclk;
        sync_n     = sync;
        din_n      = din;
        busy_n     = busy;
        gnt_n      = gnt_id;
        ack_n      = '0;
        load       = 1'b0;
        load_real  = 1'b0;
        load_frame = frame_real;
`ifdef DAC_AUTOPD_EN
        idle_n     = idle_cnt;
        last_pd_n  = last_pd;
`endif
        case (state)
            IDLE: begin
`ifdef DAC_AUTOPD_EN
                if (found) begin
                    load      = 1'b1;
                    load_real = 1'b1;
                    idle_n    = '0;
                    last_pd_n = 1'b0;
                end else if (idle_cnt == PDW'(PD_TIMEOUT)) begin
                    if (!last_pd) begin
                        load       = 1'b1;
                        load_frame = PD_FRAME;
                        last_pd_n  = 1'b1;
                        idle_n     = '0;
                    end
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
`else
                if (found) begin
                    load      = 1'b1;
                    load_real = 1'b1;
                end
`endif
            end
            SHIFT: begin
                if (hc == 8'(CLKDIV - 1)) begin
                    hc_n = '0;
                    if (sclk) begin
                        sclk_n = 1'b0;
                    end else if (bit_cnt == 4'd0) begin
                        sync_n  = 1'b1;
                        din_n   = 1'b0;
                        gap_n   = '0;
                        state_n = GAP;
                    end else begin
                        bit_n  = bit_cnt - 4'd1;
                        din_n  = shift_reg[bit_cnt - 4'd1];
                        sclk_n = 1'b1;
                    end
                end else begin
                    hc_n = hc + 8'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GCW'(GAP_CYC - 1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        if (load) begin
            state_n = SHIFT;
            shift_n = load_frame;
            din_n   = load_frame[15];
            bit_n   = 4'd15;
            hc_n    = '0;
            sclk_n  = 1'b1;
            sync_n  = 1'b0;
            busy_n  = 1'b1;
        end
        // Power-down frames leave ack, gnt_id and the round-robin pointer untouched.
        if (load_real) begin
            ack_n = ack_onehot[NREQ-1:0];
            gnt_n = win;
            ptr_n = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            hc        <= '0;
            gap_cnt   <= '0;
            sclk      <= 1'b0;
            sync      <= 1'b1;
            din       <= 1'b0;
            busy      <= 1'b0;
            gnt_id    <= '0;
            ack       <= '0;
`ifdef DAC_AUTOPD_EN
            idle_cnt  <= '0;
            last_pd   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            shift_reg <= shift_n;
            bit_cnt   <= bit_n;
            hc        <= hc_n;
            gap_cnt   <= gap_n;
            sclk      <= sclk_n;
            sync      <= sync_n;
            din       <= din_n;
            busy      <= busy_n;
            gnt_id    <= gnt_n;
            ack       <= ack_n;
`ifdef DAC_AUTOPD_EN
            idle_cnt  <= idle_n;
            last_pd   <= last_pd_n;
`endif
        end
    end

endmodule
